// File: rtl/i2c_slave.sv
`timescale 1ns/1ps
// i2c_slave: I2C target (responder) for a single 7-bit address, oversampled on clk.
// scl/sda are synchronized and glitch-filtered, START/STOP are detected, the
// address is matched and ACKed, and data moves between the bus and a byte-wide
// user interface. The slave never stretches the clock.
//
// Ports:
//   clk        system clock (>= 20x scl frequency)
//   reset      asynchronous active-high reset
//   sda        open-drain data line, driven only to 0 or z
//   scl        bus clock from the master (input only)
//   ack_en     1 = ACK written data bytes, 0 = NACK them
//   rx_data    last byte written by the master
//   rx_valid   one-clk pulse when rx_data updates
//   tx_data    byte to return on the next read
//   tx_req     one-clk pulse asking for tx_data for the next read byte
//   rw         R/W bit of the current transaction (1 = read)
//   busy       high from an address match until STOP or mismatch
//   start_det  one-clk pulse on START / repeated START
//   stop_det   one-clk pulse on STOP
//   state      current FSM state for debug
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         FILTER     = 3
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        sda,
    input  logic       scl,
    input  logic       ack_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       rw,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det,
    output logic [3:0] state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WR_BYTE   = 3'd3,
        WR_ACK    = 3'd4,
        RD_BYTE   = 3'd5,
        RD_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    // Input path; index 0 = scl, index 1 = sda.
    logic [1:0] sync1, sync2, filt, filt_d;
    logic [2:0] fcnt [2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 2'b11;
            sync2   <= 2'b11;
            filt    <= 2'b11;
            filt_d  <= 2'b11;
            fcnt[0] <= 3'd0;
            fcnt[1] <= 3'd0;
        end else begin
            sync1  <= {sda, scl};
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                // The filtered level only follows after FILTER consecutive
                // samples disagree with it; any agreeing sample restarts the count.
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= 3'd0;
                end else if (fcnt[i] == 3'(FILTER - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= 3'd0;
                end else begin
                    fcnt[i] <= fcnt[i] + 3'd1;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, sda_rise, sda_fall, start_c, stop_c;
    assign scl_f    = filt[0];
    assign sda_f    = filt[1];
    assign scl_rise = filt[0] & ~filt_d[0];
    assign scl_fall = ~filt[0] & filt_d[0];
    assign sda_rise = filt[1] & ~filt_d[1];
    assign sda_fall = ~filt[1] & filt_d[1];
    assign start_c  = sda_fall & scl_f;
    assign stop_c   = sda_rise & scl_f;

    // FSM and datapath registers.
    state_t     st, st_n;
    logic [2:0] bit_cnt, cnt_n;
    logic [7:0] shreg, sh_n, rx_n;
    logic       oe, oe_n;       // 1 = pull sda low
    logic       armed, armed_n; // ACK slot: first scl_fall seen / master ACK seen
    logic       rxv_n, txr_n, rw_n, busy_n, sd_n, pd_n;

    assign sda   = oe ? 1'b0 : 1'bz;
    assign state = {1'b0, st};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= IDLE;
            bit_cnt   <= 3'd7;
            shreg     <= 8'h00;
            oe        <= 1'b0;
            armed     <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            rw        <= 1'b0;
            busy      <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            st        <= st_n;
            bit_cnt   <= cnt_n;
            shreg     <= sh_n;
            oe        <= oe_n;
            armed     <= armed_n;
            rx_data   <= rx_n;
            rx_valid  <= rxv_n;
            tx_req    <= txr_n;
            rw        <= rw_n;
            busy      <= busy_n;
            start_det <= sd_n;
            stop_det  <= pd_n;
        end
    end

    always_comb begin
        st_n    = st;
        cnt_n   = bit_cnt;
        sh_n    = shreg;
        oe_n    = oe;
        armed_n = armed;
        rx_n    = rx_data;
        rxv_n   = 1'b0;
        txr_n   = 1'b0;
        rw_n    = rw;
        busy_n  = busy;
        sd_n    = 1'b0;
        pd_n    = 1'b0;

        if (start_c) begin
            st_n  = ADDR;
            cnt_n = 3'd7;
            oe_n  = 1'b0;
            sd_n  = 1'b1;
        end else if (stop_c) begin
            st_n   = IDLE;
            oe_n   = 1'b0;
            busy_n = 1'b0;
            pd_n   = 1'b1;
        end else begin
            case (st)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        sh_n  = {shreg[6:0], sda_f};
                        cnt_n = bit_cnt - 3'd1; // wraps 0 -> 7 at the byte boundary
                        if (bit_cnt == 3'd0) begin
                            // General call (0x00) is deliberately not answered.
                            if (sh_n[7:1] == SLAVE_ADDR && sh_n[7:1] != 7'd0) begin
                                rw_n    = sh_n[0];
                                busy_n  = 1'b1;
                                armed_n = 1'b0;
                                st_n    = ADDR_ACK;
                            end else begin
                                busy_n = 1'b0;
                                st_n   = WAIT_STOP;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!armed) begin
                            oe_n    = 1'b1;
                            armed_n = 1'b1;
                            txr_n   = rw;
                        end else begin
                            armed_n = 1'b0;
                            if (rw) begin
                                sh_n = tx_data;
                                oe_n = ~tx_data[7];
                                st_n = RD_BYTE;
                            end else begin
                                oe_n = 1'b0;
                                st_n = WR_BYTE;
                            end
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        sh_n  = {shreg[6:0], sda_f};
                        cnt_n = bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) begin
                            rx_n    = sh_n;
                            rxv_n   = 1'b1;
                            armed_n = 1'b0;
                            st_n    = WR_ACK;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        if (!armed) begin
                            oe_n    = ack_en;
                            armed_n = 1'b1;
                        end else begin
                            // oe still holds the ACK/NACK decision here.
                            oe_n    = 1'b0;
                            armed_n = 1'b0;
                            st_n    = oe ? WR_BYTE : WAIT_STOP;
                        end
                    end
                end
                RD_BYTE: begin
                    if (scl_rise) begin
                        cnt_n = bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) begin
                            armed_n = 1'b0;
                            st_n    = RD_ACK;
                        end
                    end else if (scl_fall) begin
                        oe_n = ~shreg[bit_cnt];
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_f) begin
                            txr_n   = 1'b1;
                            armed_n = 1'b1;
                        end else begin
                            st_n = WAIT_STOP;
                        end
                    end else if (scl_fall) begin
                        if (armed) begin
                            sh_n    = tx_data;
                            oe_n    = ~tx_data[7];
                            armed_n = 1'b0;
                            st_n    = RD_BYTE;
                        end else begin
                            oe_n = 1'b0; // release after the last data bit
                        end
                    end
                end
                WAIT_STOP: oe_n = 1'b0;
                default:   st_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
`timescale 1ns/1ps
module tb_i2c_slave;

  localparam logic [6:0] SLAVE_ADDR = 7'h50;
  localparam int Q = 8; // quarter scl period in clk cycles

  // ---------------- clock / reset / bus ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda_oe = 1'b0;
  logic       ack_en = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, rw, busy, start_det, stop_det;
  logic [3:0] state;
  wire        sda_bus;

  assign sda_bus = m_sda_oe ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(SLAVE_ADDR), .FILTER(3)) dut (
    .clk(clk), .reset(reset), .sda(sda_bus), .scl(scl), .ack_en(ack_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req),
    .rw(rw), .busy(busy), .start_det(start_det), .stop_det(stop_det), .state(state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- monitor / tx responder ----------------
  int         rx_cnt = 0, tx_cnt = 0, sd_cnt = 0, pd_cnt = 0;
  logic [7:0] rx_log [256];
  logic [7:0] tx_src [256];
  logic [7:0] wr_buf [8];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt % 256] = rx_data;
      rx_cnt++;
    end
    if (tx_req) begin
      tx_data = tx_src[tx_cnt % 256];
      tx_cnt++;
    end
    if (start_det) sd_cnt++;
    if (stop_det) pd_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  // ---------------- master driver tasks ----------------
  task automatic wait_q(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start();
    m_sda_oe = 1'b0; wait_q(Q);
    scl = 1'b1;      wait_q(2*Q);
    m_sda_oe = 1'b1; wait_q(2*Q);
    scl = 1'b0;      wait_q(Q);
  endtask

  task automatic m_stop();
    m_sda_oe = 1'b1; wait_q(Q);
    scl = 1'b1;      wait_q(2*Q);
    m_sda_oe = 1'b0; wait_q(2*Q);
  endtask

  task automatic m_bit_w(input logic b, input logic glitch);
    m_sda_oe = !b;
    if (glitch) begin
      wait_q(Q/2); scl = 1'b1; wait_q(1); scl = 1'b0; wait_q(Q/2 - 1);
    end else begin
      wait_q(Q);
    end
    scl = 1'b1; wait_q(2*Q);
    scl = 1'b0; wait_q(Q);
  endtask

  task automatic m_bit_r(output logic b);
    m_sda_oe = 1'b0; wait_q(Q);
    scl = 1'b1;      wait_q(Q);
    b = sda_bus;     wait_q(Q);
    scl = 1'b0;      wait_q(Q);
  endtask

  task automatic m_byte_w(input logic [7:0] d, input int glitch_bit, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) m_bit_w(d[i], i == glitch_bit);
    m_bit_r(b);
    acked = !b;
  endtask

  task automatic m_byte_r(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      m_bit_r(b);
      d[i] = b;
    end
    m_bit_w(!ack, 1'b0);
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset = 1'b1;
    wait_q(4);
    reset = 1'b0;
    wait_q(2);
    checks++;
    if ({state, rx_data, rx_valid, tx_req, rw, busy, start_det, stop_det, sda_bus} !== {4'd0, 8'd0, 6'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: actual state=%0d rx_data=%h flags=%b%b%b%b%b%b sda=%b, required all zero and sda=1",
               state, rx_data, rx_valid, tx_req, rw, busy, start_det, stop_det, sda_bus);
    end
  endtask

  // Reference: a matching address is ACKed; each data byte is received and
  // ACKed according to ack_en until the first NACK, after which the slave
  // ignores the bus (no ACK, no rx_valid) until STOP.
  task automatic run_write(input logic [6:0] a, input int n, input logic ae,
                           input int glitch_byte, input string name);
    int rx0, pd0, sd0;
    logic acked, match, active, exp_ack;
    logic [7:0] exp_q[$];
    logic [3:0] exp_state;
    rx0 = rx_cnt; pd0 = pd_cnt; sd0 = sd_cnt;
    ack_en = ae;
    m_start();
    checks++;
    if (sd_cnt - sd0 !== 1) begin
      errors++; $display("FAIL %s start_det: actual %0d pulses, required 1", name, sd_cnt - sd0);
    end
    m_byte_w({a, 1'b0}, -1, acked);
    match = (a == SLAVE_ADDR) && (a != 7'd0);
    checks++;
    if (acked !== match) begin
      errors++; $display("FAIL %s addr_ack: actual %b, required %b", name, acked, match);
    end
    checks++;
    if (busy !== match) begin
      errors++; $display("FAIL %s busy: actual %b, required %b", name, busy, match);
    end
    if (match) begin
      checks++;
      if (rw !== 1'b0) begin
        errors++; $display("FAIL %s rw: actual %b, required 0", name, rw);
      end
    end
    active = match;
    for (int i = 0; i < n; i++) begin
      m_byte_w(wr_buf[i], (i == glitch_byte) ? 3 : -1, acked);
      exp_ack = active && ae;
      checks++;
      if (acked !== exp_ack) begin
        errors++; $display("FAIL %s data_ack[%0d]: actual %b, required %b", name, i, acked, exp_ack);
      end
      if (active) exp_q.push_back(wr_buf[i]);
      if (active && !ae) active = 1'b0;
    end
    exp_state = active ? 4'd3 : 4'd7;
    checks++;
    if (state !== exp_state) begin
      errors++; $display("FAIL %s state_before_stop: actual %0d, required %0d", name, state, exp_state);
    end
    checks++;
    if (rx_cnt - rx0 !== exp_q.size()) begin
      errors++; $display("FAIL %s rx_count: actual %0d, required %0d", name, rx_cnt - rx0, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_log[(rx0 + i) % 256] !== exp_q[i]) begin
          errors++; $display("FAIL %s rx_data[%0d]: actual %h, required %h", name, i, rx_log[(rx0 + i) % 256], exp_q[i]);
        end
      end
    end
    m_stop();
    checks++;
    if ({pd_cnt - pd0 == 1, busy, state, sda_bus} !== {1'b1, 1'b0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL %s after_stop: actual stops=%0d busy=%b state=%0d sda=%b, required 1/0/0/1",
                         name, pd_cnt - pd0, busy, state, sda_bus);
    end
  endtask

  // Reference: the master reads n bytes, ACKing all but the last; the bus must
  // carry the user bytes in request order and tx_req pulses once per byte.
  task automatic run_read(input int n, input string name);
    int tx0;
    logic acked;
    logic [7:0] d;
    tx0 = tx_cnt;
    for (int i = 0; i < n; i++) tx_src[(tx0 + i) % 256] = wr_buf[i];
    m_start();
    m_byte_w({SLAVE_ADDR, 1'b1}, -1, acked);
    checks++;
    if ({acked, rw, busy} !== 3'b111) begin
      errors++; $display("FAIL %s addr_phase: actual ack=%b rw=%b busy=%b, required 1/1/1", name, acked, rw, busy);
    end
    for (int i = 0; i < n; i++) begin
      m_byte_r(d, i < n - 1);
      checks++;
      if (d !== wr_buf[i]) begin
        errors++; $display("FAIL %s read_byte[%0d]: actual %h, required %h", name, i, d, wr_buf[i]);
      end
    end
    checks++;
    if (tx_cnt - tx0 !== n) begin
      errors++; $display("FAIL %s tx_req_count: actual %0d, required %0d", name, tx_cnt - tx0, n);
    end
    checks++;
    if (state !== 4'd7) begin
      errors++; $display("FAIL %s state_after_nack: actual %0d, required 7", name, state);
    end
    m_stop();
    checks++;
    if (state !== 4'd0) begin
      errors++; $display("FAIL %s state_after_stop: actual %0d, required 0", name, state);
    end
  endtask

  task automatic test_write_basic();
    wr_buf[0] = 8'h12; wr_buf[1] = 8'h34;
    run_write(SLAVE_ADDR, 2, 1'b1, -1, "write_basic");
  endtask

  task automatic test_addr_mismatch();
    wr_buf[0] = 8'h55;
    run_write(7'h51, 1, 1'b1, -1, "addr_mismatch");
  endtask

  task automatic test_general_call();
    wr_buf[0] = 8'hAA;
    run_write(7'h00, 1, 1'b1, -1, "general_call");
  endtask

  task automatic test_write_nack();
    wr_buf[0] = 8'hFF; wr_buf[1] = 8'h3C;
    run_write(SLAVE_ADDR, 2, 1'b0, -1, "write_nack");
    ack_en = 1'b1;
  endtask

  task automatic test_glitch();
    wr_buf[0] = 8'h96; wr_buf[1] = 8'h69;
    run_write(SLAVE_ADDR, 2, 1'b1, 0, "scl_glitch");
  endtask

  task automatic test_read();
    wr_buf[0] = 8'h5A; wr_buf[1] = 8'hC3;
    run_read(2, "read_basic");
  endtask

  task automatic test_repeated_start();
    int sd0, rx0, tx0;
    logic acked;
    logic [7:0] d;
    sd0 = sd_cnt; rx0 = rx_cnt; tx0 = tx_cnt;
    tx_src[tx0 % 256] = 8'hE1;
    ack_en = 1'b1;
    m_start();
    m_byte_w({SLAVE_ADDR, 1'b0}, -1, acked);
    m_byte_w(8'h07, -1, acked);
    // Partial byte, then repeated START: must be discarded.
    m_bit_w(1'b1, 1'b0); m_bit_w(1'b0, 1'b0); m_bit_w(1'b1, 1'b0);
    m_start();
    m_byte_w({SLAVE_ADDR, 1'b1}, -1, acked);
    checks++;
    if ({acked, rw} !== 2'b11) begin
      errors++; $display("FAIL rstart addr_read: actual ack=%b rw=%b, required 1/1", acked, rw);
    end
    m_byte_r(d, 1'b0);
    checks++;
    if (d !== 8'hE1) begin
      errors++; $display("FAIL rstart read_byte: actual %h, required e1", d);
    end
    m_stop();
    checks++;
    if (sd_cnt - sd0 !== 2) begin
      errors++; $display("FAIL rstart start_count: actual %0d, required 2", sd_cnt - sd0);
    end
    checks++;
    if (rx_cnt - rx0 !== 1 || rx_log[rx0 % 256] !== 8'h07) begin
      errors++; $display("FAIL rstart rx: actual count=%0d first=%h, required 1 / 07", rx_cnt - rx0, rx_log[rx0 % 256]);
    end
    checks++;
    if (tx_cnt - tx0 !== 1) begin
      errors++; $display("FAIL rstart tx_req_count: actual %0d, required 1", tx_cnt - tx0);
    end
  endtask

  task automatic test_random();
    logic [6:0] a;
    int n, gb;
    logic ae;
    for (int t = 0; t < 8; t++) begin
      a  = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : SLAVE_ADDR;
      n  = $urandom_range(1, 3);
      ae = ($urandom_range(0, 3) != 0);
      gb = ($urandom_range(0, 1) == 0) ? $urandom_range(0, n - 1) : -1;
      for (int i = 0; i < n; i++) wr_buf[i] = 8'($urandom_range(0, 255));
      run_write(a, n, ae, gb, "random_write");
    end
    ack_en = 1'b1;
    for (int t = 0; t < 3; t++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) wr_buf[i] = 8'($urandom_range(0, 255));
      run_read(n, "random_read");
    end
  endtask

  task automatic test_reset_mid_ack();
    m_start();
    for (int i = 7; i >= 0; i--) m_bit_w(((8'hA0 >> i) & 8'h01) != 0, 1'b0);
    m_sda_oe = 1'b0; wait_q(Q);
    scl = 1'b1;      wait_q(Q);
    checks++;
    if ({sda_bus, state} !== {1'b0, 4'd2}) begin
      errors++; $display("FAIL reset_mid_ack pre: actual sda=%b state=%0d, required 0 / 2", sda_bus, state);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({sda_bus, state, busy} !== {1'b1, 4'd0, 1'b0}) begin
      errors++; $display("FAIL reset_mid_ack async: actual sda=%b state=%0d busy=%b, required 1 / 0 / 0", sda_bus, state, busy);
    end
    wait_q(4);
    reset = 1'b0;
    wait_q(2*Q);
    checks++;
    if ({sda_bus, state} !== {1'b1, 4'd0}) begin
      errors++; $display("FAIL reset_mid_ack post: actual sda=%b state=%0d, required 1 / 0", sda_bus, state);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_addr_mismatch();
    test_read();
    test_repeated_start();
    test_write_nack();
    test_general_call();
    test_glitch();
    test_random();
    test_reset_mid_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C responder (target) for the open-drain bus driven by our I2C master controller; same sda/scl wiring, clocked by the system clk.
- Oversamples scl/sda, detects START/STOP, matches a 7-bit address, ACKs, and moves bytes between the bus and a byte-wide user interface.
- Does not stretch the clock: scl is input-only.

Parameters:
- SLAVE_ADDR, 7'h50, own 7-bit bus address.
- FILTER, 3, consecutive equal samples required before a filtered scl/sda level changes (glitch filter, 1..7).

Ports:
- clk  input  1  system clock, ≥ 20x the scl frequency.
- reset  input  1  asynchronous, active-high reset.
- sda  inout  1  I2C data; driven only to 0 or z (wired-AND), never driven 1.
- scl  input  1  I2C clock from master.
- ack_en  input  1  1 = ACK written data bytes; 0 = NACK them. The address is always ACKed on a match.
- rx_data  output  8  last byte written by master, MSB first.
- rx_valid  output  1  one-clk pulse when rx_data is updated.
- tx_data  input  8  byte to return on read.
- tx_req  output  1  one-clk pulse requesting tx_data for the next read byte.
- rw  output  1  R/W bit of the current transaction (1 = read).
- busy  output  1  1 from a matched address until STOP or mismatch.
- start_det  output  1  one-clk pulse on START or repeated START.
- stop_det  output  1  one-clk pulse on STOP.
- state  output  4  current FSM state, for debug.

Behaviour:
- Reset values: sda released (z), state IDLE, rx_data 0, rx_valid 0, tx_req 0, rw 0, busy 0, start_det 0, stop_det 0, bit counter 7, filters preset to 1.
- Input path:
  - 2-FF synchronizer, then the FILTER counter, giving sda_f and scl_f.
  - scl_rise / scl_fall are one-clk pulses on scl_f transitions.
  - Detection latency from a pad edge is 2+FILTER+1 clk.
- Conditions:
  - START = sda_f falls while scl_f = 1.
  - STOP = sda_f rises while scl_f = 1.
  - Both take priority over any bit activity.
  - START from any state: go to ADDR, reset the bit counter to 7, release sda, pulse start_det.
  - STOP from any state: go to IDLE, release sda, clear busy, pulse stop_det.
- Timing rule: bits are sampled on scl_rise. The slave changes sda only on scl_fall.
- FSM states (encodings 0..7):
  - IDLE(0): wait for START.
  - ADDR(1):
    - Shift 8 bits on scl_rise.
    - After the 8th, if the upper 7 bits equal SLAVE_ADDR: latch rw = bit0, set busy, go to ADDR_ACK.
    - Otherwise go to WAIT_STOP; sda stays released.
  - ADDR_ACK(2):
    - On the next scl_fall, drive sda 0.
    - If rw = 1, pulse tx_req in the same clk as that scl_fall.
    - On the following scl_fall, release sda and go to WR_BYTE (rw = 0) or RD_BYTE (rw = 1).
    - For a read, the shift register loads tx_data in that clk and drives bit 7.
    - The user therefore has one scl-low half-period plus one scl-high period between tx_req and the tx_data capture.
  - WR_BYTE(3):
    - Shift 8 bits on scl_rise.
    - After the 8th, update rx_data and pulse rx_valid in the same clk, then go to WR_ACK.
  - WR_ACK(4):
    - On scl_fall, drive sda = !ack_en.
    - On the next scl_fall, release sda and go to WR_BYTE (ACK) or WAIT_STOP (NACK).
  - RD_BYTE(5):
    - On each scl_fall, drive sda = 0 if the current bit is 0, else z.
    - Bit order is MSB first; the counter decrements on scl_rise.
    - After the 8th scl_rise, go to RD_ACK; sda is released on the next scl_fall.
  - RD_ACK(6):
    - On scl_rise, sample master ACK.
    - ACK (sda_f = 0): pulse tx_req. On the next scl_fall, load tx_data and go to RD_BYTE.
    - NACK: go to WAIT_STOP.
  - WAIT_STOP(7): sda released; ignore the bus until START or STOP.
- Boundary cases:
  - Bit counter 3-bit, wraps 0 -> 7 at each byte boundary.
  - Repeated START mid-byte discards the partial byte; no rx_valid.
  - General call address 0x00 is not supported and is treated as a mismatch.
  - Reset asserted mid-transfer releases sda in the same clk (asynchronous).

Test Plan:
- Write 0xA0 (0x50, W), bytes 0x12, 0x34, STOP, ack_en = 1:
  - Slave ACKs all three bytes.
  - rx_valid pulses twice, with rx_data 0x12 then 0x34.
  - stop_det pulses and busy returns to 0.
- Write to 0xA2 (addr 0x51):
  - No ACK on the 9th clock, busy stays 0.
  - No rx_valid; state 7 until STOP.
- Read 0xA1, tx_data = 0x5A then 0xC3, master ACKs then NACKs:
  - Bus shows 0x5A then 0xC3.
  - tx_req pulses exactly twice; the slave ends in WAIT_STOP, then IDLE after STOP.
- Write 0xA0, 0x07, repeated START, 0xA1, read 1 byte:
  - start_det pulses twice, rw becomes 1.
  - One rx_valid (0x07), one tx_req.
- ack_en = 0 during a written byte 0xFF: the slave NACKs it, rx_valid still pulses with 0xFF, and the slave goes to WAIT_STOP.
- Noise and reset:
  - 1-clk scl glitch during a byte with FILTER = 3: no extra bit is shifted.
  - Reset pulsed while the slave drives ACK: sda goes to z immediately and state = 0.
